// File: rtl/token_multiplier_pkg.sv
// Shared constants and the factor clamp for the token multiplier.
// Imported by the lane, the top level and the bench.
package token_multiplier_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_FACTOR_MAX  = 8;
    localparam int DEF_MAX_PENDING = 200;

    // Maps 0 to 1 and anything above factor_max to factor_max.
    function automatic int clamp_factor(input int factor, input int factor_max);
        if (factor < 1)
            return 1;
        else if (factor > factor_max)
            return factor_max;
        else
            return factor;
    endfunction

endpackage

// File: rtl/token_multiplier_if.sv
// Token bus between the token source and the multiplier.
// The master drives tokens and the factor; the slave returns the multiplied stream and status.
interface token_multiplier_if #(
    parameter int NUM_CH   = 4,
    parameter int FACTOR_W = 4,
    parameter int PEND_W   = 8
);

    logic [NUM_CH-1:0]        a;
    logic [FACTOR_W-1:0]      factor;
    logic [NUM_CH-1:0]        b;
    logic [NUM_CH*PEND_W-1:0] pending;
    logic [NUM_CH-1:0]        overflow;
    logic                     overflow_any;

    modport master (
        output a, factor,
        input  b, pending, overflow, overflow_any
    );

    modport slave (
        input  a, factor,
        output b, pending, overflow, overflow_any
    );

endinterface

// File: rtl/token_multiplier_lane.sv
// One lane: backlog counter with saturation, sticky overflow flag,
// and the combinational output b = a | (backlog non-empty).
module token_multiplier_lane #(
    parameter int FACTOR_W    = 4,
    parameter int PEND_W      = 8,
    parameter int MAX_PENDING = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_a,
    input  logic [FACTOR_W-1:0] i_factor,
    output logic                o_b,
    output logic [PEND_W-1:0]   o_pending,
    output logic                o_overflow
);

    // One spare bit on top of pending + factor, so the sum can never wrap.
    localparam int SUM_W = PEND_W + FACTOR_W + 1;

    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;
    logic [SUM_W-1:0]  w_nxt;
    logic              w_sat;

    // i_factor is already clamped to >= 1, so factor - 1 never goes negative.
    always_comb begin
        w_nxt = SUM_W'(r_pending);
        if (i_a)
            w_nxt = SUM_W'(r_pending) + SUM_W'(i_factor) - SUM_W'(1);
        else if (r_pending != '0)
            w_nxt = SUM_W'(r_pending) - SUM_W'(1);
    end

    assign w_sat = (w_nxt > SUM_W'(MAX_PENDING));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset is synchronous, hence the plain posedge list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= w_sat ? PEND_W'(MAX_PENDING) : w_nxt[PEND_W-1:0];
            if (w_sat)
                r_overflow <= 1'b1;
        end
    end

    assign o_b        = rst & (i_a | (r_pending != '0));
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/token_multiplier.sv
// Multi-lane serial token multiplier: every incoming '1' on a lane becomes F consecutive '1's.
// Holds the global factor clamp, the pending bus packing and the registered overflow summary.
module token_multiplier
    import token_multiplier_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int FACTOR_MAX  = DEF_FACTOR_MAX,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int FACTOR_W    = $clog2(FACTOR_MAX + 1),
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    token_multiplier_if.slave bus
);

    logic [FACTOR_W-1:0] w_factor_eff;
    logic [NUM_CH-1:0]   w_b;
    logic [NUM_CH-1:0]   w_overflow;
    logic [PEND_W-1:0]   w_pending [NUM_CH];
    logic                r_overflow_any;

    assign w_factor_eff = FACTOR_W'(clamp_factor(int'(bus.factor), FACTOR_MAX));

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        token_multiplier_lane #(
            .FACTOR_W   (FACTOR_W),
            .PEND_W     (PEND_W),
            .MAX_PENDING(MAX_PENDING)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_a       (bus.a[gi]),
            .i_factor  (w_factor_eff),
            .o_b       (w_b[gi]),
            .o_pending (w_pending[gi]),
            .o_overflow(w_overflow[gi])
        );

        assign bus.pending[gi*PEND_W +: PEND_W] = w_pending[gi];
    end

    // Summary flag lags the per-lane flags by one cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            r_overflow_any <= 1'b0;
        else
            r_overflow_any <= |w_overflow;
    end

    assign bus.b            = w_b;
    assign bus.overflow     = w_overflow;
    assign bus.overflow_any = r_overflow_any;

endmodule

// File: tb/tb_token_multiplier.sv
// Scoreboard bench for token_multiplier: a per-lane backlog model predicts b before the edge
// and pending/overflow after it; scenario tasks add direct checks of the documented cases.
module tb_token_multiplier;
    import token_multiplier_pkg::*;

    localparam int NUM_CH   = DEF_NUM_CH;
    localparam int FMAX     = DEF_FACTOR_MAX;
    localparam int MAXP     = DEF_MAX_PENDING;
    localparam int FACTOR_W = $clog2(FMAX + 1);
    localparam int PEND_W   = $clog2(MAXP + 1);

    typedef struct {
        logic [NUM_CH-1:0]        b;
        logic [NUM_CH*PEND_W-1:0] pend;
        logic [NUM_CH-1:0]        ovf;
        logic                     ovf_any;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    token_multiplier_if #(.NUM_CH(NUM_CH), .FACTOR_W(FACTOR_W), .PEND_W(PEND_W)) bus ();

    token_multiplier #(
        .NUM_CH     (NUM_CH),
        .FACTOR_MAX (FMAX),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t              sb[$];
    int                m_pend[NUM_CH];
    bit                m_ovf[NUM_CH];
    bit                m_ovf_any;
    logic [NUM_CH-1:0] last_b;
    int                n_cmp = 0;
    int                n_err = 0;

    function automatic int lane_pend(input int i);
        return int'(bus.pending[i*PEND_W +: PEND_W]);
    endfunction

    // One clock cycle: drive, predict, check b before the edge and the state after it.
    task automatic cycle(input logic [NUM_CH-1:0] a_v, input int f, input logic rst_v);
        exp_t e;
        int   eff;
        int   nxt;
        bit   any_old;
        @(negedge clk);
        rst        = rst_v;
        bus.a      = a_v;
        bus.factor = FACTOR_W'(f);
        #1;
        eff     = (f < 1) ? 1 : ((f > FMAX) ? FMAX : f);
        any_old = 1'b0;
        for (int i = 0; i < NUM_CH; i++) any_old |= m_ovf[i];
        for (int i = 0; i < NUM_CH; i++) begin
            e.b[i] = rst_v && (a_v[i] || (m_pend[i] != 0));
            if (!rst_v) begin
                m_pend[i] = 0;
                m_ovf[i]  = 1'b0;
            end else begin
                if (a_v[i])          nxt = m_pend[i] + eff - 1;
                else if (m_pend[i] > 0) nxt = m_pend[i] - 1;
                else                 nxt = 0;
                if (nxt > MAXP) begin
                    nxt      = MAXP;
                    m_ovf[i] = 1'b1;
                end
                m_pend[i] = nxt;
            end
            e.pend[i*PEND_W +: PEND_W] = PEND_W'(m_pend[i]);
            e.ovf[i] = m_ovf[i];
        end
        m_ovf_any = rst_v ? any_old : 1'b0;
        e.ovf_any = m_ovf_any;
        sb.push_back(e);

        last_b = bus.b;
        n_cmp++;
        if (bus.b !== sb[0].b) begin
            n_err++;
            $display("FAIL sb_b t=%0t got=%b exp=%b", $time, bus.b, sb[0].b);
        end

        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (bus.pending !== e.pend) begin
            n_err++;
            $display("FAIL sb_pending t=%0t got=%h exp=%h", $time, bus.pending, e.pend);
        end
        n_cmp++;
        if (bus.overflow !== e.ovf) begin
            n_err++;
            $display("FAIL sb_overflow t=%0t got=%b exp=%b", $time, bus.overflow, e.ovf);
        end
        n_cmp++;
        if (bus.overflow_any !== e.ovf_any) begin
            n_err++;
            $display("FAIL sb_overflow_any t=%0t got=%b exp=%b", $time, bus.overflow_any, e.ovf_any);
        end
    endtask

    task automatic test_reset();
        cycle('1, 2, 1'b0);
        n_cmp++;
        if (last_b !== '0) begin
            n_err++;
            $display("FAIL reset_b got=%b exp=0", last_b);
        end
        cycle('1, 8, 1'b0);
        n_cmp++;
        if (bus.pending !== '0 || bus.overflow !== '0 || bus.overflow_any !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state pend=%h ovf=%b any=%b exp all 0",
                     bus.pending, bus.overflow, bus.overflow_any);
        end
    endtask

    task automatic test_doubler();
        logic [25:0] pat;
        logic [25:0] exp_b;
        logic [25:0] got_b;
        pat   = 26'b10010011000110100001100100;
        exp_b = 26'b11011011110111111001111110;
        for (int k = 25; k >= 0; k--) begin
            cycle({NUM_CH{pat[k]}}, 2, 1'b1);
            got_b[k] = last_b[0];
        end
        n_cmp++;
        if (got_b !== exp_b) begin
            n_err++;
            $display("FAIL doubler_stream got=%b exp=%b", got_b, exp_b);
        end
        n_cmp++;
        if (bus.overflow !== '0) begin
            n_err++;
            $display("FAIL doubler_overflow got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_factor3();
        int exp_p[3];
        exp_p = '{2, 1, 0};
        cycle(4'b0001, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (lane_pend(0) != exp_p[k]) begin
                n_err++;
                $display("FAIL factor3_pending step=%0d got=%0d exp=%0d", k, lane_pend(0), exp_p[k]);
            end
            if (k < 2) cycle('0, 3, 1'b1);
        end
        cycle('0, 3, 1'b1);
        n_cmp++;
        if (last_b !== '0) begin
            n_err++;
            $display("FAIL factor3_idle_b got=%b exp=0", last_b);
        end
    endtask

    task automatic test_factor_clamp();
        logic [NUM_CH-1:0] a_v;
        for (int k = 0; k < 16; k++) begin
            a_v = NUM_CH'($urandom);
            cycle(a_v, k % 2, 1'b1);
            n_cmp++;
            if (last_b !== a_v || bus.pending !== '0) begin
                n_err++;
                $display("FAIL clamp_low f=%0d b=%b a=%b pend=%h", k % 2, last_b, a_v, bus.pending);
            end
        end
        cycle(4'b0001, FMAX + 1, 1'b1);
        n_cmp++;
        if (lane_pend(0) != FMAX - 1) begin
            n_err++;
            $display("FAIL clamp_high got=%0d exp=%0d", lane_pend(0), FMAX - 1);
        end
        cycle(4'b0010, 15, 1'b1);
        n_cmp++;
        if (lane_pend(1) != FMAX - 1) begin
            n_err++;
            $display("FAIL clamp_max got=%0d exp=%0d", lane_pend(1), FMAX - 1);
        end
        for (int k = 0; k < FMAX; k++) cycle('0, 1, 1'b1);
    endtask

    task automatic test_overflow();
        int ones;
        cycle('0, 2, 1'b0);
        for (int k = 0; k < MAXP; k++) cycle('1, 2, 1'b1);
        n_cmp++;
        if (lane_pend(0) != MAXP || bus.overflow !== '0) begin
            n_err++;
            $display("FAIL ovf_edge pend=%0d ovf=%b exp=%0d/0", lane_pend(0), bus.overflow, MAXP);
        end
        cycle('1, 2, 1'b1);
        n_cmp++;
        if (lane_pend(0) != MAXP || bus.overflow !== '1) begin
            n_err++;
            $display("FAIL ovf_set pend=%0d ovf=%b exp=%0d/1111", lane_pend(0), bus.overflow, MAXP);
        end
        ones = 0;
        for (int k = 0; k < MAXP; k++) begin
            cycle('0, 2, 1'b1);
            if (last_b[0]) ones++;
        end
        n_cmp++;
        if (ones != MAXP || lane_pend(0) != 0) begin
            n_err++;
            $display("FAIL ovf_drain ones=%0d pend=%0d exp=%0d/0", ones, lane_pend(0), MAXP);
        end
        n_cmp++;
        if (bus.overflow !== '1 || bus.overflow_any !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky ovf=%b any=%b exp=1111/1", bus.overflow, bus.overflow_any);
        end
        cycle('0, 2, 1'b0);
        n_cmp++;
        if (bus.overflow !== '0) begin
            n_err++;
            $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_lanes();
        cycle(4'b0101, 2, 1'b1);
        n_cmp++;
        if (lane_pend(0) != 1 || lane_pend(2) != 1 || lane_pend(1) != 0 || lane_pend(3) != 0) begin
            n_err++;
            $display("FAIL lanes_even pend=%h exp lanes0/2=1 lanes1/3=0", bus.pending);
        end
        cycle(4'b1010, 4, 1'b1);
        n_cmp++;
        if (lane_pend(1) != 3 || lane_pend(3) != 3 || lane_pend(0) != 0 || lane_pend(2) != 0) begin
            n_err++;
            $display("FAIL lanes_odd pend=%h exp lanes1/3=3 lanes0/2=0", bus.pending);
        end
        for (int k = 0; k < 4; k++) cycle('0, 4, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        cycle(4'b0001, 6, 1'b1);
        n_cmp++;
        if (lane_pend(0) != 5) begin
            n_err++;
            $display("FAIL mid_setup got=%0d exp=5", lane_pend(0));
        end
        cycle('0, 6, 1'b0);
        n_cmp++;
        if (last_b !== '0 || bus.pending !== '0 || bus.overflow !== '0) begin
            n_err++;
            $display("FAIL mid_reset b=%b pend=%h ovf=%b exp all 0", last_b, bus.pending, bus.overflow);
        end
        cycle(4'b0001, 3, 1'b1);
        n_cmp++;
        if (last_b[0] !== 1'b1 || lane_pend(0) != 2) begin
            n_err++;
            $display("FAIL mid_after b=%b pend=%0d exp=1/2", last_b[0], lane_pend(0));
        end
        for (int k = 0; k < 3; k++) cycle('0, 3, 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        bus.a      = '0;
        bus.factor = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 1'b0;
        end
        m_ovf_any = 1'b0;

        test_reset();
        test_doubler();
        test_factor3();
        test_factor_clamp();
        test_overflow();
        test_lanes();
        test_reset_mid_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/token_multiplier.md
# token_multiplier

Serial token multiplier for the bit-stream processing chain. Each input lane replaces every incoming token '1' with FACTOR consecutive '1's on its output lane, using a backlog counter of pending tokens. This is the multi-lane, run-time-factor generalisation of the fixed ×2 doubler. Each lane has a saturating backlog and a sticky overflow flag.

## Interface
- NUM_CH, 4: number of independent lanes.
- FACTOR_MAX, 8: largest multiplication factor accepted on `factor`.
- MAX_PENDING, 200: largest backlog a lane must hold; exceeding it is an overflow.
- FACTOR_W, $clog2(FACTOR_MAX+1): derived; do not override.
- PEND_W, $clog2(MAX_PENDING+1): derived; do not override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- a  input  NUM_CH  token input, one bit per lane per cycle.
- factor  input  FACTOR_W  global multiplication factor, applied to each token on the cycle the token arrives.
- b  output  NUM_CH  token output, one bit per lane.
- pending  output  NUM_CH*PEND_W  per-lane backlog counter (lane i at bits [i*PEND_W +: PEND_W]).
- overflow  output  NUM_CH  per-lane sticky overflow.
- overflow_any  output  1  registered OR of all overflow bits.

## Operation
- Effective factor F = factor, clamped to the range 1..FACTOR_MAX.
  - 0 is treated as 1.
  - Values above FACTOR_MAX are treated as FACTOR_MAX.
- Per lane, combinational output: b[i] = a[i] | (pending_i != 0). Force b to 0 while rst = 0.
- Per-lane update of `pending` each cycle:
  - a[i]=1: nxt = pending + (F−1). The token's first copy leaves on b in the same cycle.
  - a[i]=0 and pending>0: nxt = pending − 1.
  - a[i]=0 and pending=0: pending is unchanged.
- Arithmetic width: compute nxt in PEND_W+FACTOR_W+1 bits, so no wrap is possible before the comparison.
- Saturation:
  - If nxt > MAX_PENDING, pending is loaded with MAX_PENDING; the excess copies are dropped.
  - overflow[i] is set on that same clock edge.
- overflow[i] is sticky; only rst = 0 clears it.
  - The lane keeps multiplying normally while overflow[i] = 1.
- Lanes are fully independent; a change of `factor` affects only tokens that arrive on or after the change.
- There is no state machine per lane. Each lane has two regions:
  - IDLE: pending = 0.
  - DRAIN: pending > 0.

## Timing
- b is combinational from a and registered from pending: zero-cycle latency for the first copy. The remaining F−1 copies follow in consecutive cycles whenever no new token arrives.
- A token arriving while the lane is in DRAIN still outputs 1 in that cycle and adds F−1 to the backlog. Throughput of '1's on b is one per cycle.
- overflow[i] rises on the clock edge that ends the cycle carrying the offending token, so it is visible in the next cycle.
- overflow_any follows one cycle after overflow.
- Reset values:
  - pending = 0.
  - overflow = 0.
  - overflow_any = 0.
  - b = 0 while in reset.
- Reset asserted mid-drain: on the next edge pending is 0, overflow is 0, and no further copies are output.

## Structure
- Package `token_multiplier_pkg` contains:
  - default constants DEF_NUM_CH, DEF_FACTOR_MAX, DEF_MAX_PENDING;
  - function `clamp_factor`, which implements the 0→1 and >FACTOR_MAX→FACTOR_MAX mapping.
- Sub-module `token_multiplier_lane`, instantiated NUM_CH times in a generate loop.
  - Contains: one lane's pending counter, saturation logic, sticky overflow and b.
  - The top level holds the factor clamp, the pending bus packing and the overflow_any register.

## Test plan
- NUM_CH=1, factor=2, a=10010011000110100001100100 → b=11011011110111111001111110, overflow stays 0.
- factor=3, single token a=1 followed by zeros → b=1110…; pending goes 2,1,0; lane returns to IDLE after 3 cycles.
- factor=0 and factor=1 → b identical to a, pending always 0; factor=FACTOR_MAX+1 behaves as FACTOR_MAX.
- factor=2, MAX_PENDING=200, 201 consecutive ones:
  - After 200 ones, pending=200 and overflow=0.
  - The 201st token sets overflow=1 with pending held at 200.
  - Then a=0: b drains 200 ones and pending reaches 0; overflow stays 1 until rst=0.
- 4 lanes, a=4'b0101 with factor=2 for one cycle, then factor=4 with a=4'b1010 for one cycle:
  - Lanes 0 and 2 show pending 1.
  - Lanes 1 and 3 show pending 3.
  - No cross-lane interaction.
- Reset while pending=5: pulse rst=0 for one cycle → pending=0, b=0, overflow=0; a token on the next cycle is multiplied normally.
